// File: rtl/scramble_key_gen_pkg.sv
// Shared types and constants for the FFT-bin reorder key generator.
// A key is eight 3-bit block indices; slot k lives in bits [3k+2:3k].
package scramble_pkg;

  localparam int          NBLK         = 8;
  localparam int          KEY_W        = NBLK * 3;
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  typedef logic [2:0] blk_idx_t;
  typedef blk_idx_t [NBLK-1:0] perm_t;

  typedef enum logic [1:0] {
    GEN_L = 2'd0,
    GEN_R = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic perm_t identity_perm();
    perm_t p;
    for (int k = 0; k < NBLK; k++) p[k] = blk_idx_t'(k);
    return p;
  endfunction

endpackage

// File: rtl/scramble_key_gen_if.sv
// Control strobes in, committed key pair and status out, for the key generator.
interface scramble_key_gen_if;
  import scramble_pkg::*;

  // No valid/ready here: frame_start and seed_load are single-cycle strobes that
  // are always accepted on the posedge they are high; outputs are registered and
  // key_l/key_r only change on the cycle after an accepted frame_start.
  logic             frame_start;
  logic             scramble_en;
  logic             seed_load;
  logic [31:0]      seed_in;
  logic [KEY_W-1:0] key_l;
  logic [KEY_W-1:0] key_r;
  logic             key_valid;
  logic             key_stale;
  logic             busy;
  state_t           dbg_state;
  logic [31:0]      dbg_lfsr;

  modport master (
    output frame_start, scramble_en, seed_load, seed_in,
    input  key_l, key_r, key_valid, key_stale, busy, dbg_state, dbg_lfsr
  );

  modport slave (
    input  frame_start, scramble_en, seed_load, seed_in,
    output key_l, key_r, key_valid, key_stale, busy, dbg_state, dbg_lfsr
  );

endinterface

// File: rtl/scramble_key_gen_lfsr.sv
// 32-bit right-shifting Galois LFSR; shared with the receiver-side key generator.
// A load of zero is replaced by 1 so the register can never lock up.
module scramble_lfsr32
  import scramble_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  localparam logic [31:0] RESET_VAL = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == 32'h0) ? 32'h1 : load_val;
    end else if (step) begin
      state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_POLY : 32'h0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= RESET_VAL;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/scramble_key_gen.sv
// Builds the next (key_l, key_r) permutation pair in the background with a
// Fisher-Yates shuffle and commits it on frame_start (double-buffered).
module scramble_key_gen
  import scramble_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic               clock,
  input  logic               reset,
  scramble_key_gen_if.slave  bus
);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  perm_t            perm_q, perm_d, perm_sw;
  perm_t            pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic             pend_ok_q, pend_ok_d;
  logic [KEY_W-1:0] key_l_q, key_l_d, key_r_q, key_r_d;
  logic             key_valid_q, key_valid_d;
  logic             key_stale_q, key_stale_d;
  logic [31:0]      lfsr;
  logic [10:0]      prod;
  blk_idx_t         j;
  logic             gen_active;

  assign gen_active = (state_q == GEN_L) || (state_q == GEN_R);

  scramble_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .step     (gen_active),
    .load     (bus.seed_load),
    .load_val (bus.seed_in),
    .state    (lfsr)
  );

  // One shuffle step: j = (rnd8 * (i+1)) >> 8 is always <= i.
  always_comb begin
    prod    = 11'(lfsr[7:0]) * 11'({1'b0, cnt_q} + 4'd1);
    j       = blk_idx_t'(prod >> 8);
    perm_sw = perm_q;
    perm_sw[cnt_q] = perm_q[j];
    perm_sw[j]     = perm_q[cnt_q];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    perm_d      = perm_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    pend_ok_d   = pend_ok_q;
    key_l_d     = key_l_q;
    key_r_d     = key_r_q;
    key_valid_d = key_valid_q;
    key_stale_d = 1'b0;

    unique case (state_q)
      GEN_L: begin
        perm_d = perm_sw;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          pend_l_d = perm_sw;
          perm_d   = identity_perm();
          cnt_d    = 3'd7;
          state_d  = GEN_R;
        end
      end
      GEN_R: begin
        perm_d = perm_sw;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          pend_r_d  = perm_sw;
          pend_ok_d = 1'b1;
          state_d   = DONE;
        end
      end
      default: begin
        // DONE without a pending pair only happens straight out of reset.
        if (!pend_ok_q) begin
          perm_d  = identity_perm();
          cnt_d   = 3'd7;
          state_d = GEN_L;
        end
      end
    endcase

    if (bus.seed_load) begin
      pend_ok_d   = 1'b0;
      key_valid_d = 1'b0;
      key_stale_d = bus.frame_start;
      perm_d      = identity_perm();
      cnt_d       = 3'd7;
      state_d     = GEN_L;
    end else if (bus.frame_start) begin
      if (pend_ok_q) begin
        // The pair is consumed even in bypass so paired LFSRs stay in step.
        key_l_d     = bus.scramble_en ? pend_l_q : '0;
        key_r_d     = bus.scramble_en ? pend_r_q : '0;
        key_valid_d = 1'b1;
        pend_ok_d   = 1'b0;
        perm_d      = identity_perm();
        cnt_d       = 3'd7;
        state_d     = GEN_L;
      end else begin
        key_stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DONE;
      cnt_q       <= 3'd7;
      perm_q      <= identity_perm();
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      pend_ok_q   <= 1'b0;
      key_l_q     <= '0;
      key_r_q     <= '0;
      key_valid_q <= 1'b0;
      key_stale_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      perm_q      <= perm_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_ok_q   <= pend_ok_d;
      key_l_q     <= key_l_d;
      key_r_q     <= key_r_d;
      key_valid_q <= key_valid_d;
      key_stale_q <= key_stale_d;
    end
  end

  assign bus.key_l     = key_l_q;
  assign bus.key_r     = key_r_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_stale = key_stale_q;
  assign bus.busy      = gen_active;
  assign bus.dbg_state = state_q;
  assign bus.dbg_lfsr  = lfsr;

endmodule

// File: tb/tb_scramble_key_gen.sv
// Directed bench for scramble_key_gen: reference shuffle model feeds an expected
// queue at each frame_start; a twin instance checks stream reproducibility.
module tb_scramble_key_gen;

  localparam logic [31:0] TB_SEED = 32'hACE1_2468;
  localparam logic [31:0] TB_POLY = 32'h8020_0003;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  scramble_key_gen_if bus();
  scramble_key_gen_if bus2();

  assign bus2.frame_start = bus.frame_start;
  assign bus2.scramble_en = bus.scramble_en;
  assign bus2.seed_load   = bus.seed_load;
  assign bus2.seed_in     = bus.seed_in;

  scramble_key_gen #(.SEED(TB_SEED)) dut  (.clock(clock), .reset(reset), .bus(bus));
  scramble_key_gen #(.SEED(TB_SEED)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  // scoreboard state
  int          checks = 0;
  int          failures = 0;
  logic [47:0] exp_q[$];
  logic [31:0] m_lfsr;
  logic [23:0] cur_l, cur_r;
  int          stale_seen = 0;
  int          twin_diff = 0;

  always @(negedge clock) begin
    if (bus.key_stale === 1'b1) stale_seen++;
    if ({bus.key_l, bus.key_r, bus.key_valid, bus.key_stale} !==
        {bus2.key_l, bus2.key_r, bus2.key_valid, bus2.key_stale}) twin_diff++;
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // reference model
  function automatic logic [31:0] m_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TB_POLY : 32'h0);
  endfunction

  task automatic m_gen(output logic [23:0] k);
    int p[8];
    int r, j, t;
    k = '0;
    for (int c = 0; c < 8; c++) p[c] = c;
    for (int i = 7; i >= 1; i--) begin
      r = int'(m_lfsr[7:0]);
      j = (r * (i + 1)) >> 8;
      t = p[i]; p[i] = p[j]; p[j] = t;
      m_lfsr = m_step(m_lfsr);
    end
    for (int c = 0; c < 8; c++) k[3*c +: 3] = 3'(p[c]);
  endtask

  function automatic logic is_perm(input logic [23:0] k);
    logic [7:0] seen;
    seen = '0;
    for (int c = 0; c < 8; c++) seen[k[3*c +: 3]] = 1'b1;
    return seen == 8'hFF;
  endfunction

  // driver: one frame_start strobe, then the check of the following cycle
  task automatic do_frame(input logic en, input logic expect_stale);
    logic [23:0] kl, kr;
    logic [47:0] exp;
    bus.frame_start = 1'b1;
    bus.scramble_en = en;
    if (!expect_stale) begin
      m_gen(kl);
      m_gen(kr);
      if (!en) begin
        kl = '0;
        kr = '0;
      end
      exp_q.push_back({kl, kr});
    end
    tick();
    bus.frame_start = 1'b0;
    if (expect_stale) begin
      check("stale_pulse", 48'(bus.key_stale), 48'd1);
      check("stale_hold", {bus.key_l, bus.key_r}, {cur_l, cur_r});
    end else begin
      exp = exp_q.pop_front();
      check("commit_keys", {bus.key_l, bus.key_r}, exp);
      check("commit_valid", 48'(bus.key_valid), 48'd1);
      check("commit_no_stale", 48'(bus.key_stale), 48'd0);
      check("commit_busy", 48'(bus.busy), 48'd1);
      if (en) check("commit_perm", 48'({is_perm(bus.key_l), is_perm(bus.key_r)}), 48'd3);
      {cur_l, cur_r} = exp;
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.scramble_en = 1'b1;
    bus.seed_load   = 1'b0;
    bus.seed_in     = '0;
    reset  = 1'b1;
    m_lfsr = TB_SEED;
    cur_l  = '0;
    cur_r  = '0;

    // reset values
    tick(3);
    check("reset_keys", {bus.key_l, bus.key_r}, 48'd0);
    check("reset_valid", 48'(bus.key_valid), 48'd0);
    check("reset_stale", 48'(bus.key_stale), 48'd0);
    check("reset_busy", 48'(bus.busy), 48'd0);
    check("reset_lfsr", 48'(bus.dbg_lfsr), 48'(TB_SEED));
    reset = 1'b0;
    tick();
    check("gen_starts", 48'(bus.busy), 48'd1);
    tick(19);
    check("gen_done_idle", 48'(bus.busy), 48'd0);
    check("no_valid_before_frame", 48'(bus.key_valid), 48'd0);

    // long run: frames 3-4 in bypass, frame 5 must be the model's 5th pair
    for (int n = 1; n <= 1000; n++) begin
      do_frame(!(n == 3 || n == 4), 1'b0);
      tick(63);
    end
    check("no_stale_in_run", 48'(stale_seen), 48'd0);

    // frame_start 5 cycles after the previous one
    do_frame(1'b1, 1'b0);
    tick(4);
    do_frame(1'b1, 1'b1);
    tick();
    check("stale_one_cycle", 48'(bus.key_stale), 48'd0);
    check("stale_hold_after", {bus.key_l, bus.key_r}, {cur_l, cur_r});
    tick(62);
    do_frame(1'b1, 1'b0);
    check("stale_count", 48'(stale_seen), 48'd1);
    tick(63);

    // seed_load of zero in the middle of generation
    do_frame(1'b1, 1'b0);
    tick(5);
    bus.seed_load = 1'b1;
    bus.seed_in   = 32'h0;
    tick();
    bus.seed_load = 1'b0;
    check("seed0_lfsr", 48'(bus.dbg_lfsr), 48'd1);
    check("seed0_valid", 48'(bus.key_valid), 48'd0);
    check("seed0_hold", {bus.key_l, bus.key_r}, {cur_l, cur_r});
    check("seed0_busy", 48'(bus.busy), 48'd1);
    m_lfsr = 32'h1;
    tick(20);
    do_frame(1'b1, 1'b0);
    tick(63);

    // seed_load and frame_start together: seed_load wins, frame is stale
    bus.seed_load   = 1'b1;
    bus.seed_in     = 32'h1234_5678;
    bus.frame_start = 1'b1;
    tick();
    bus.seed_load   = 1'b0;
    bus.frame_start = 1'b0;
    check("both_stale", 48'(bus.key_stale), 48'd1);
    check("both_hold", {bus.key_l, bus.key_r}, {cur_l, cur_r});
    check("both_valid", 48'(bus.key_valid), 48'd0);
    check("both_lfsr", 48'(bus.dbg_lfsr), 48'h1234_5678);
    m_lfsr = 32'h1234_5678;
    tick(20);
    do_frame(1'b1, 1'b0);

    // reset in the middle of generation
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_keys", {bus.key_l, bus.key_r}, 48'd0);
    check("midreset_valid", 48'(bus.key_valid), 48'd0);
    check("midreset_busy", 48'(bus.busy), 48'd0);
    cur_l  = '0;
    cur_r  = '0;
    m_lfsr = TB_SEED;
    exp_q.delete();
    tick(20);
    do_frame(1'b1, 1'b0);
    tick(5);

    check("twin_streams", 48'(twin_diff), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
